// File: rtl/dig_quad_pkg.sv
// Shared types and helpers for the quadrature decoder: step classification
// enum, terminal-count resolution and the Gray-position step classifier.
package dig_quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    localparam logic [1:0] PRIME_EDGES = 2'd2;

    function automatic int maxVal(input int maxValue, input int Bits);
        return (maxValue == 0) ? ((1 << Bits) - 1) : maxValue;
    endfunction

    // (A,B) maps onto a 2-bit ring position 00->0, 10->1, 11->2, 01->3 so the
    // step direction falls out of a modulo-4 difference.
    function automatic step_t classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] prev_pos;
        logic [1:0] cur_pos;
        logic [1:0] delta;
        prev_pos = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
        cur_pos  = {cur_ab[0], cur_ab[1] ^ cur_ab[0]};
        delta    = cur_pos - prev_pos;
        case (delta)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            default: return STEP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/dig_quad_step.sv
// Phase synchronizers, previous-state register and step classification.
// While priming, the previous-state register tracks the value entering stage 2.
module dig_quad_step
    import dig_quad_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_a,
    input  logic  i_b,
    input  logic  i_prime,
    output step_t o_step
);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
        end else begin
            r_sync1 <= {i_a, i_b};
            r_sync2 <= r_sync1;
            r_prev  <= i_prime ? r_sync1 : r_sync2;
        end
    end

    always_comb begin
        o_step = STEP_NONE;
        if (!i_prime) begin
            o_step = classify(r_prev, r_sync2);
        end
    end

endmodule

// File: rtl/dig_quad_decoder.sv
// Quadrature (x4) position decoder: wrapping position count with load/clear,
// direction, wrap pulse and sticky illegal-transition flag.
module dig_quad_decoder
    import dig_quad_pkg::*;
#(
    parameter int Bits     = 2,
    parameter int maxValue = 0
) (
    input  logic            C,
    input  logic            nRst,
    input  logic            A,
    input  logic            B,
    input  logic            en,
    input  logic            clr,
    input  logic            ld,
    input  logic [Bits-1:0] in,
    output logic [Bits-1:0] out,
    output logic            dir,
    output logic            ovf,
    output logic            err
);

    if (Bits < 2) begin : g_bits_check
        $error("dig_quad_decoder: Bits must be at least 2");
    end

    localparam logic [Bits-1:0] MAX_CNT = Bits'(maxVal(maxValue, Bits));
    localparam logic [Bits-1:0] CNT_ONE = Bits'(1);

    logic [Bits-1:0] r_count;
    logic            r_dir;
    logic            r_ovf;
    logic            r_err;
    logic [1:0]      r_prime_cnt;
    logic            w_priming;
    step_t           w_step;

    assign w_priming = (r_prime_cnt != PRIME_EDGES);

    dig_quad_step u_step (
        .i_clk   (C),
        .i_rst_n (nRst),
        .i_a     (A),
        .i_b     (B),
        .i_prime (w_priming),
        .o_step  (w_step)
    );

    always_ff @(posedge C or negedge nRst) begin
        if (!nRst) begin
            r_prime_cnt <= 2'd0;
            r_count     <= '0;
            r_dir       <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_priming) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
            r_ovf <= 1'b0;
            if (w_step == STEP_FWD) begin
                r_dir <= 1'b0;
            end else if (w_step == STEP_REV) begin
                r_dir <= 1'b1;
            end
            if (clr) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_step == STEP_ERR) begin
                    r_err <= 1'b1;
                end
                // Loaded values above the terminal count only wrap at 2^Bits.
                if (ld) begin
                    r_count <= in;
                end else if (en && (w_step == STEP_FWD)) begin
                    if (r_count == MAX_CNT) begin
                        r_count <= '0;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end else if (en && (w_step == STEP_REV)) begin
                    if (r_count == '0) begin
                        r_count <= MAX_CNT;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
            end
        end
    end

    assign out = r_count;
    assign dir = r_dir;
    assign ovf = r_ovf;
    assign err = r_err;

endmodule

// File: tb/tb_dig_quad_decoder.sv
// Bench for dig_quad_decoder: two instances (terminal 15 and 9) driven in
// parallel, directed scenarios plus random stimulus against a reference model.
module tb_dig_quad_decoder;

    logic       C    = 1'b0;
    logic       nRst = 1'b0;
    logic       A    = 1'b1;
    logic       B    = 1'b1;
    logic       en   = 1'b1;
    logic       clr  = 1'b0;
    logic       ld   = 1'b0;
    logic [3:0] in_v = 4'd0;
    logic [1:0] ab   = 2'b11;

    logic [3:0] out0, out9;
    logic       dir0, dir9, ovf0, ovf9, err0, err9;

    int checks   = 0;
    int failures = 0;

    dig_quad_decoder #(.Bits(4), .maxValue(0)) dut0 (
        .C(C), .nRst(nRst), .A(A), .B(B), .en(en), .clr(clr), .ld(ld), .in(in_v),
        .out(out0), .dir(dir0), .ovf(ovf0), .err(err0)
    );

    dig_quad_decoder #(.Bits(4), .maxValue(9)) dut9 (
        .C(C), .nRst(nRst), .A(A), .B(B), .en(en), .clr(clr), .ld(ld), .in(in_v),
        .out(out9), .dir(dir9), .ovf(ovf9), .err(err9)
    );

    always #5 C = ~C;

    // ---------------- reference model ----------------
    function automatic int ring_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ring_val(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] next_ab(input logic [1:0] v, input int d);
        return ring_val((ring_pos(v) + d + 4) % 4);
    endfunction

    int         m_cnt[2];
    bit         m_dir[2];
    bit         m_ovf[2];
    bit         m_err[2];
    int         mx[2] = '{15, 9};
    int         m_edges = 0;
    logic [1:0] hist[$];

    // Edge n after reset release: a step is the move between the pin samples
    // taken at edges n-3 and n-2; nothing moves before edge 4.
    always @(posedge C or negedge nRst) begin
        int mv;
        int d;
        if (!nRst) begin
            hist.delete();
            m_edges = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_dir[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
            end
        end else begin
            hist.push_back({A, B});
            if (hist.size() > 4) void'(hist.pop_front());
            if (m_edges < 4) m_edges++;
            mv = 0;
            if (m_edges >= 4) begin
                d  = (ring_pos(hist[1]) - ring_pos(hist[0]) + 4) % 4;
                mv = (d == 0) ? 0 : (d == 1) ? 1 : (d == 3) ? 2 : 3;
            end
            for (int i = 0; i < 2; i++) begin
                m_ovf[i] = 0;
                if (mv == 1) m_dir[i] = 0;
                else if (mv == 2) m_dir[i] = 1;
                if (clr) begin
                    m_cnt[i] = 0;
                    m_err[i] = 0;
                end else begin
                    if (mv == 3) m_err[i] = 1;
                    if (ld) m_cnt[i] = int'(in_v);
                    else if (en && mv == 1) begin
                        if (m_cnt[i] == mx[i]) begin m_cnt[i] = 0; m_ovf[i] = 1; end
                        else m_cnt[i] = (m_cnt[i] + 1) % 16;
                    end else if (en && mv == 2) begin
                        if (m_cnt[i] == 0) begin m_cnt[i] = mx[i]; m_ovf[i] = 1; end
                        else m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    end

    task automatic set_ab(input logic [1:0] v);
        ab = v;
        A  = v[1];
        B  = v[0];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge C);
        checks++;
        if (out0 !== 4'd0 || err0 !== 1'b0 || dir0 !== 1'b0 || ovf0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got out=%0d err=%0b dir=%0b ovf=%0b exp all 0", out0, err0, dir0, ovf0);
        end
        nRst = 1'b1;
        repeat (4) @(negedge C);
        checks++;
        if (out0 !== 4'd0 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_prime0 got out=%0d err=%0b exp out=0 err=0", out0, err0);
        end
        checks++;
        if (out9 !== 4'd0 || err9 !== 1'b0) begin
            failures++;
            $display("FAIL reset_prime9 got out=%0d err=%0b exp out=0 err=0", out9, err9);
        end
    endtask

    task automatic test_forward();
        for (int k = 0; k < 8; k++) begin
            set_ab(next_ab(ab, 1));
            @(negedge C);
            @(negedge C);
            checks++;
            if (out0 !== 4'(k)) begin
                failures++;
                $display("FAIL fwd_early step=%0d got=%0d exp=%0d", k, out0, k);
            end
            @(negedge C);
            checks++;
            if (out0 !== 4'(k + 1) || dir0 !== 1'b0) begin
                failures++;
                $display("FAIL fwd_step step=%0d got out=%0d dir=%0b exp out=%0d dir=0", k, out0, dir0, k + 1);
            end
        end
        checks++;
        if (out0 !== 4'd8) begin
            failures++;
            $display("FAIL fwd_final got=%0d exp=8", out0);
        end
    endtask

    task automatic test_wrap();
        ld = 1'b1; in_v = 4'd9;
        @(negedge C);
        ld = 1'b0;
        checks++;
        if (out9 !== 4'd9) begin failures++; $display("FAIL wrap_load got=%0d exp=9", out9); end
        set_ab(next_ab(ab, 1));
        repeat (2) @(negedge C);
        checks++;
        if (out9 !== 4'd9 || ovf9 !== 1'b0) begin
            failures++; $display("FAIL wrap_early got out=%0d ovf=%0b exp out=9 ovf=0", out9, ovf9);
        end
        @(negedge C);
        checks++;
        if (out9 !== 4'd0 || ovf9 !== 1'b1 || dir9 !== 1'b0) begin
            failures++; $display("FAIL wrap_fwd got out=%0d ovf=%0b dir=%0b exp out=0 ovf=1 dir=0", out9, ovf9, dir9);
        end
        @(negedge C);
        checks++;
        if (ovf9 !== 1'b0 || out9 !== 4'd0) begin
            failures++; $display("FAIL wrap_fwd_pulse got out=%0d ovf=%0b exp out=0 ovf=0", out9, ovf9);
        end
        set_ab(next_ab(ab, -1));
        repeat (3) @(negedge C);
        checks++;
        if (out9 !== 4'd9 || ovf9 !== 1'b1 || dir9 !== 1'b1) begin
            failures++; $display("FAIL wrap_rev got out=%0d ovf=%0b dir=%0b exp out=9 ovf=1 dir=1", out9, ovf9, dir9);
        end
        @(negedge C);
        checks++;
        if (ovf9 !== 1'b0) begin failures++; $display("FAIL wrap_rev_pulse got ovf=%0b exp 0", ovf9); end
        ld = 1'b1; in_v = 4'd15;
        @(negedge C);
        ld = 1'b0;
        set_ab(next_ab(ab, 1));
        repeat (3) @(negedge C);
        checks++;
        if (out9 !== 4'd0 || ovf9 !== 1'b0) begin
            failures++; $display("FAIL wrap_above_max got out=%0d ovf=%0b exp out=0 ovf=0", out9, ovf9);
        end
        checks++;
        if (out0 !== 4'd0 || ovf0 !== 1'b1) begin
            failures++; $display("FAIL wrap_full_range got out=%0d ovf=%0b exp out=0 ovf=1", out0, ovf0);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] o;
        logic       d;
        ld = 1'b1; in_v = 4'd6;
        @(negedge C);
        ld = 1'b0;
        o = 4'd6;
        d = dir0;
        set_ab(~ab);
        repeat (3) @(negedge C);
        checks++;
        if (err0 !== 1'b1 || out0 !== o || dir0 !== d) begin
            failures++; $display("FAIL illegal_err got err=%0b out=%0d dir=%0b exp err=1 out=%0d dir=%0b", err0, out0, dir0, o, d);
        end
        clr = 1'b1;
        @(negedge C);
        clr = 1'b0;
        checks++;
        if (err0 !== 1'b0 || out0 !== 4'd0) begin
            failures++; $display("FAIL illegal_clr got err=%0b out=%0d exp err=0 out=0", err0, out0);
        end
    endtask

    task automatic test_enable();
        ld = 1'b1; in_v = 4'd5;
        @(negedge C);
        ld = 1'b0;
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_ab(next_ab(ab, -1));
            repeat (3) @(negedge C);
        end
        checks++;
        if (out0 !== 4'd5 || dir0 !== 1'b1 || ovf0 !== 1'b0) begin
            failures++; $display("FAIL en_low got out=%0d dir=%0b ovf=%0b exp out=5 dir=1 ovf=0", out0, dir0, ovf0);
        end
        set_ab(next_ab(ab, 1));
        repeat (2) @(negedge C);
        clr = 1'b1; ld = 1'b1; in_v = 4'd7;
        @(negedge C);
        clr = 1'b0; ld = 1'b0;
        checks++;
        if (out0 !== 4'd0 || dir0 !== 1'b0 || err0 !== 1'b0) begin
            failures++; $display("FAIL clr_ld_step got out=%0d dir=%0b err=%0b exp out=0 dir=0 err=0", out0, dir0, err0);
        end
        en = 1'b1;
    endtask

    task automatic test_mid_reset();
        ld = 1'b1; in_v = 4'd3;
        @(negedge C);
        ld = 1'b0;
        set_ab(next_ab(ab, 1));
        @(negedge C);
        nRst = 1'b0;
        #1;
        checks++;
        if (out0 !== 4'd0 || dir0 !== 1'b0 || err0 !== 1'b0) begin
            failures++; $display("FAIL midrst_async got out=%0d dir=%0b err=%0b exp all 0", out0, dir0, err0);
        end
        @(negedge C);
        nRst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge C);
            checks++;
            if (out0 !== 4'd0 || err0 !== 1'b0 || ovf0 !== 1'b0) begin
                failures++; $display("FAIL midrst_release cyc=%0d got out=%0d err=%0b ovf=%0b exp all 0", j, out0, err0, ovf0);
            end
        end
    endtask

    task automatic test_random();
        int         r;
        logic [3:0] g_out;
        logic       g_dir, g_ovf, g_err;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge C);
            for (int i = 0; i < 2; i++) begin
                g_out = (i == 0) ? out0 : out9;
                g_dir = (i == 0) ? dir0 : dir9;
                g_ovf = (i == 0) ? ovf0 : ovf9;
                g_err = (i == 0) ? err0 : err9;
                checks++;
                if (g_out !== 4'(m_cnt[i])) begin
                    failures++; $display("FAIL rnd_out inst=%0d cyc=%0d got=%0d exp=%0d", i, cyc, g_out, m_cnt[i]);
                end
                checks++;
                if (g_dir !== m_dir[i]) begin
                    failures++; $display("FAIL rnd_dir inst=%0d cyc=%0d got=%0b exp=%0b", i, cyc, g_dir, m_dir[i]);
                end
                checks++;
                if (g_ovf !== m_ovf[i]) begin
                    failures++; $display("FAIL rnd_ovf inst=%0d cyc=%0d got=%0b exp=%0b", i, cyc, g_ovf, m_ovf[i]);
                end
                checks++;
                if (g_err !== m_err[i]) begin
                    failures++; $display("FAIL rnd_err inst=%0d cyc=%0d got=%0b exp=%0b", i, cyc, g_err, m_err[i]);
                end
            end
            r = int'($urandom_range(0, 99));
            if (r >= 35 && r < 65) set_ab(next_ab(ab, 1));
            else if (r >= 65 && r < 95) set_ab(next_ab(ab, -1));
            else if (r >= 95) set_ab(~ab);
            en   = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            ld   = ($urandom_range(0, 19) == 0);
            in_v = 4'($urandom_range(0, 15));
        end
        clr = 1'b0;
        ld  = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_illegal();
        test_enable();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
